// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage that feeds the IF/ID pipeline register.
// It owns the program counter and keeps at most one instruction-memory read
// in flight over a req/valid handshake. Returned words go straight into the
// IF/ID register when ID can take them. Otherwise they park in a one-entry
// skid buffer until the ID-stage stall drops.
//
// A redirect from EX (taken branch or jump) flushes everything the stage
// holds and restarts fetching at the new target. A read that is still in
// flight when the redirect arrives cannot be cancelled on the memory side,
// so its data is marked to be discarded when it eventually returns.
//
// Parameters
//   RESET_PC   PC value after reset (start of .text)
//   CNT_WIDTH  width of the saturating bubble counter
//
// Ports
//   clock              single clock, all state changes on the rising edge
//   reset              asynchronous, active-high reset
//   imem_req           read request, held high until imem_valid
//   imem_addr          word-aligned fetch address, stable while imem_req is high
//   imem_valid         one-cycle pulse, imem_rdata belongs to the open request
//   imem_rdata         instruction word returned by memory
//   stall              ID cannot accept, IF/ID outputs must hold
//   redirect           flush and restart fetching at redirect_pc
//   redirect_pc        redirect target, low two bits ignored
//   if_id_valid        IF/ID payload holds a real instruction
//   if_id_pc           PC of if_id_instruction
//   if_id_instruction  fetched instruction, NOP (addi x0,x0,0) when invalid
//   bubble_count       saturating count of cycles with no valid IF/ID and no stall
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic                 imem_valid,
  input  logic [31:0]          imem_rdata,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  output logic                 if_id_valid,
  output logic [31:0]          if_id_pc,
  output logic [31:0]          if_id_instruction,
  output logic [CNT_WIDTH-1:0] bubble_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // IDLE only ever lasts the single cycle after reset.
  // REQ keeps a memory read open.
  // SKID parks one word while ID is stalled.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SKID = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] pc;
  logic        discard;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;

  logic        out_free;
  logic        take_word;
  logic        to_skid;
  logic        from_skid;
  logic [31:0] target;
  logic        unused_target_low;

  // Targets are always word aligned, so the two low bits of redirect_pc
  // carry no information and are dropped.
  assign target            = {redirect_pc[31:2], 2'b00};
  assign unused_target_low = ^redirect_pc[1:0];

  // ID can take a new word when IF/ID is empty or is being consumed this cycle.
  assign out_free = !if_id_valid || !stall;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and per-cycle control decisions.
  // Redirect overrides everything: no word is delivered or parked in that
  // cycle, and the FSM always returns to REQ to fetch the new target.
  always_comb begin
    state_next = state;
    take_word  = 1'b0;
    to_skid    = 1'b0;
    from_skid  = 1'b0;
    imem_req   = 1'b0;

    case (state)
      IDLE: begin
        state_next = REQ;
      end

      REQ: begin
        imem_req = 1'b1;
        if (imem_valid && !discard) begin
          if (out_free) begin
            take_word = 1'b1;
          end else begin
            to_skid    = 1'b1;
            state_next = SKID;
          end
        end
      end

      SKID: begin
        if (!stall) begin
          from_skid  = 1'b1;
          state_next = REQ;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (redirect) begin
      take_word  = 1'b0;
      to_skid    = 1'b0;
      from_skid  = 1'b0;
      state_next = REQ;
    end
  end

  // PC, request address and discard flag.
  // imem_addr equals pc except while a redirected-away read is still open.
  // In that window it keeps the old address until the stale data comes back.
  // A redirect that coincides with imem_valid closes the read at once,
  // so the new address can be presented straight away and nothing needs
  // discarding.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      imem_addr <= RESET_PC;
      discard   <= 1'b0;
    end else if (redirect) begin
      pc <= target;
      if (state != REQ || imem_valid) begin
        imem_addr <= target;
      end
      discard <= (state == REQ) && !imem_valid;
    end else if (state == REQ && imem_valid) begin
      if (discard) begin
        imem_addr <= pc;
        discard   <= 1'b0;
      end else begin
        pc        <= pc + 32'd4;
        imem_addr <= pc + 32'd4;
      end
    end
  end

  // IF/ID payload register.
  // A stall holds the payload exactly. Without a stall and without a new
  // word, the payload turns into a bubble. if_id_pc is left alone on a
  // bubble because it is meaningless while if_id_valid is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if_id_valid       <= 1'b0;
      if_id_pc          <= 32'h0000_0000;
      if_id_instruction <= NOP;
    end else if (redirect) begin
      if_id_valid       <= 1'b0;
      if_id_instruction <= NOP;
    end else if (take_word) begin
      if_id_valid       <= 1'b1;
      if_id_pc          <= imem_addr;
      if_id_instruction <= imem_rdata;
    end else if (from_skid) begin
      if_id_valid       <= 1'b1;
      if_id_pc          <= skid_pc;
      if_id_instruction <= skid_instr;
    end else if (!stall) begin
      if_id_valid       <= 1'b0;
      if_id_instruction <= NOP;
    end
  end

  // Skid buffer data.
  // Whether the entry is full is carried by the SKID state, so flushing it
  // on a redirect only needs the state change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      skid_pc    <= 32'h0000_0000;
      skid_instr <= NOP;
    end else if (to_skid) begin
      skid_pc    <= imem_addr;
      skid_instr <= imem_rdata;
    end
  end

  // Bubble counter.
  // It counts cycles where ID was free but received nothing, and sticks at
  // all-ones instead of wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bubble_count <= '0;
    end else if (!if_id_valid && !stall && bubble_count != CNT_MAX) begin
      bubble_count <= bubble_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Randomised bench for fetch_stage.
//
// A behavioural memory answers each request after 1 to 3 cycles. The data
// it returns is a fixed function of the request address.
//
// The reference model is the program-order stream that ID should see.
// It starts at the reset PC and advances by 4 per instruction. A redirect
// restarts the stream at the aligned target and kills anything not yet
// taken. The stimulus side pushes upcoming entries into a queue. A separate
// monitor pops an entry whenever ID takes a valid instruction and compares
// the two.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam int          CNT_WIDTH = 8;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic                 clock;
  logic                 reset;
  logic                 imem_req;
  logic [31:0]          imem_addr;
  logic                 imem_valid;
  logic [31:0]          imem_rdata;
  logic                 stall;
  logic                 redirect;
  logic [31:0]          redirect_pc;
  logic                 if_id_valid;
  logic [31:0]          if_id_pc;
  logic [31:0]          if_id_instruction;
  logic [CNT_WIDTH-1:0] bubble_count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] tail_pc;
  int          compared   = 0;
  int          mismatched = 0;
  int          consumed   = 0;
  logic        mem_enable = 1'b0;
  int          bub_model  = 0;

  fetch_stage #(
    .RESET_PC (RESET_PC),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_valid       (imem_valid),
    .imem_rdata       (imem_rdata),
    .stall            (stall),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .if_id_valid      (if_id_valid),
    .if_id_pc         (if_id_pc),
    .if_id_instruction(if_id_instruction),
    .bubble_count     (bubble_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Word stored at address a; distinct for every word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, required, $time);
    end
  endtask

  task automatic topUp();
    exp_t e;
    while (exp_q.size() < 8) begin
      e.pc    = tail_pc;
      e.instr = mem_word(tail_pc);
      exp_q.push_back(e);
      tail_pc = tail_pc + 32'd4;
    end
  endtask

  // Drives one cycle of ID/EX-side inputs just after the rising edge.
  // A redirect restarts the expected program-order stream.
  task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc);
    @(posedge clock);
    #1;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    if (rd) begin
      exp_q.delete();
      tail_pc = {rpc[31:2], 2'b00};
    end
    topUp();
  endtask

  // Asserts reset right now (between edges) and checks the reset values
  // immediately. It then holds reset over two rising edges and releases it
  // on a falling edge. The memory stays disabled afterwards.
  task automatic doReset();
    reset      = 1'b1;
    mem_enable = 1'b0;
    imem_valid = 1'b0;
    stall      = 1'b0;
    redirect   = 1'b0;
    exp_q.delete();
    tail_pc = RESET_PC;
    topUp();
    #1;
    checkOutput("reset_imem_req", imem_req, 0);
    checkOutput("reset_imem_addr", imem_addr, RESET_PC);
    checkOutput("reset_if_id_valid", if_id_valid, 0);
    checkOutput("reset_if_id_pc", if_id_pc, 0);
    checkOutput("reset_if_id_instr", if_id_instruction, NOP);
    checkOutput("reset_bubble_count", bubble_count, 0);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Memory-side samples of the request, taken mid-cycle.
  logic        req_s;
  logic [31:0] addr_s;
  initial begin
    req_s  = 1'b0;
    addr_s = '0;
    forever begin
      @(negedge clock);
      req_s  = imem_req;
      addr_s = imem_addr;
    end
  end

  // Behavioural instruction memory: one read at a time, random latency 1..3.
  initial begin : memory_model
    logic        busy;
    logic [31:0] lat_addr;
    int          cnt;
    busy     = 1'b0;
    lat_addr = '0;
    cnt      = 0;
    forever begin
      @(posedge clock);
      #1;
      if (reset || !mem_enable) begin
        busy       = 1'b0;
        imem_valid = 1'b0;
      end else if (imem_valid) begin
        imem_valid = 1'b0;
        busy       = 1'b0;
      end else if (busy) begin
        checkOutput("req_held", req_s, 1);
        checkOutput("addr_stable", addr_s, lat_addr);
        cnt--;
        if (cnt <= 0) begin
          imem_valid = 1'b1;
          imem_rdata = mem_word(lat_addr);
        end
      end else if (req_s) begin
        busy     = 1'b1;
        lat_addr = addr_s;
        cnt      = $urandom_range(3, 1) - 1;
        if (cnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = mem_word(lat_addr);
        end
      end
    end
  end

  // Bubble counter reference: with IF/ID known empty, every rising edge
  // outside reset with stall low adds one, saturating at 2^CNT_WIDTH-1.
  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        bub_model = 0;
      end else if (!stall && bub_model < (1 << CNT_WIDTH) - 1) begin
        bub_model = bub_model + 1;
      end
    end
  end

  // Monitor: pops the expected stream whenever ID takes an instruction.
  initial begin : monitor
    logic rd_prev;
    exp_t e;
    rd_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        rd_prev = 1'b0;
      end else begin
        if (rd_prev) begin
          checkOutput("flush_if_id_valid", if_id_valid, 0);
          checkOutput("flush_imem_req", imem_req, 1);
        end
        if (!if_id_valid) begin
          checkOutput("nop_when_invalid", if_id_instruction, NOP);
        end else if (!stall && !redirect) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL sb_underflow: actual pc=%h required=queued entry", if_id_pc);
          end else begin
            e = exp_q.pop_front();
            checkOutput("sb_pc", if_id_pc, e.pc);
            checkOutput("sb_instr", if_id_instruction, e.instr);
            consumed++;
          end
        end
        rd_prev = redirect;
      end
    end
  end

  initial begin : main
    int  n;
    logic st;
    logic rd;
    logic [31:0] rpc;

    reset       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_valid  = 1'b0;
    imem_rdata  = '0;
    tail_pc     = RESET_PC;
    #1;
    doReset();

    // Memory silent: IF/ID stays empty, so bubbles are fully predictable.
    repeat (10) applyStimulus(0, 0, 0);
    @(negedge clock);
    checkOutput("bubble_count_run", bubble_count, bub_model);
    checkOutput("bubble_count_ten", bubble_count, 10);
    checkOutput("idle_req_held", imem_req, 1);
    checkOutput("idle_req_addr", imem_addr, RESET_PC);
    repeat (5) applyStimulus(1, 0, 0);
    @(negedge clock);
    checkOutput("bubble_count_stalled", bubble_count, bub_model);
    repeat (300) applyStimulus(0, 0, 0);
    @(negedge clock);
    checkOutput("bubble_count_saturate", bubble_count, 8'hFF);
    checkOutput("bubble_count_model", bubble_count, bub_model);

    // A stray imem_valid in the IDLE cycle right after reset must be ignored.
    @(negedge clock);
    #2;
    doReset();
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clock);
    @(negedge clock);
    checkOutput("late_valid_ignored", if_id_valid, 0);
    mem_enable = 1'b1;

    // Random stall / redirect traffic, with some targets near the top of
    // the address space.
    for (int i = 0; i < 2500; i++) begin
      st  = ($urandom_range(2, 0) == 0);
      rd  = ($urandom_range(19, 0) == 0);
      rpc = $urandom;
      if ($urandom_range(3, 0) == 0) begin
        rpc = 32'hFFFF_FFE0 | (rpc & 32'h0000_001F);
      end
      applyStimulus(st, rd, rpc);
    end

    // PC wrap: the stream continues from 0xFFFFFFFC to 0x00000000.
    applyStimulus(0, 1, 32'hFFFF_FFF6);
    repeat (40) applyStimulus(0, 0, 0);

    // Fill the skid under stall, then redirect while still stalled.
    n = 0;
    applyStimulus(1, 0, 0);
    @(negedge clock);
    while (n < 30 && !(!imem_req && if_id_valid)) begin
      applyStimulus(1, 0, 0);
      @(negedge clock);
      n++;
    end
    checkOutput("skid_reached", (n < 30), 1);
    applyStimulus(1, 1, 32'h0040_0203);
    applyStimulus(0, 0, 0);
    @(negedge clock);
    checkOutput("skid_flush_valid", if_id_valid, 0);
    checkOutput("skid_flush_req", imem_req, 1);
    repeat (40) applyStimulus(0, 0, 0);

    // Asynchronous reset while a read is open.
    n = 0;
    @(negedge clock);
    while (n < 20 && !(imem_req && !imem_valid)) begin
      @(negedge clock);
      n++;
    end
    #2;
    doReset();
    mem_enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(($urandom_range(3, 0) == 0), ($urandom_range(29, 0) == 0), $urandom);
    end
    @(negedge clock);

    compared++;
    if (consumed < 200) begin
      mismatched++;
      $display("[TB] FAIL progress: actual=%0d required>=200 instructions delivered", consumed);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
